// File: rtl/sram_arbiter_pkg.sv
// sram_pkg: shared definitions for the SRAM frontend arbiter.
//   state_e   - arbiter FSM states
//   REQ_A/B   - requester ids (A = programmer loader, B = core data path)
//   BE_*      - byte-enable encodings forwarded to the frontend
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_WORD = 2'b11;

endpackage

// File: rtl/sram_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter.
//   clk, rst    - clock, async active-high reset
//   req[1:0]    - request vector, bit 0 = A, bit 1 = B
//   advance     - commit the current grant into last_grant
//   gnt[1:0]    - one-hot grant (0 when no request)
//   last_grant  - most recently committed winner (resets to B so A wins first tie)
module rr_arbiter2
  import sram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       last_grant
);

  logic last_grant_q, last_grant_d;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant_q == REQ_B) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (advance) last_grant_d = gnt[1] ? REQ_B : REQ_A;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= REQ_B;
    else     last_grant_q <= last_grant_d;
  end

  assign last_grant = last_grant_q;

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM frontend between requester A (loader) and
// requester B (core). Round-robin, one transaction outstanding, timeout
// forces an error completion if the frontend hangs.
//   a_*/b_*  - requester ports: valid/ready accept, rvalid/rdata/err completion
//   m_*      - frontend port: valid/ready issue, done/rdata completion
//   busy     - FSM not idle
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_write,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic [1:0]            a_be,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  a_err,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_write,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  input  logic [1:0]            b_be,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  b_err,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_write,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [1:0]            m_be,
  input  logic                  m_done,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  output logic                  busy
);

  localparam int              CW       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam bit              TO_EN    = (TIMEOUT_CYCLES > 0);

  state_e                  state_q, state_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [1:0]              be_q, be_d;
  logic [CW-1:0]           cnt_q, cnt_d, cnt_inc;
  logic                    a_rv_q, a_rv_d, b_rv_q, b_rv_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              gnt;
  logic                    owner;
  logic                    accept;
  logic                    expired;

  // last_grant is committed at accept rather than at completion: the arbiter
  // only consults it in IDLE, which is re-entered only after completion, so
  // the register doubles as the owner latch.
  rr_arbiter2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        ({b_valid, a_valid}),
    .advance    (accept),
    .gnt        (gnt),
    .last_grant (owner)
  );

  assign accept  = (state_q == IDLE) && (gnt != 2'b00);
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign expired = TO_EN && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    cnt_d   = cnt_q;
    a_rv_d  = 1'b0;
    b_rv_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          write_d = gnt[1] ? b_write : a_write;
          addr_d  = gnt[1] ? b_addr  : a_addr;
          wdata_d = gnt[1] ? b_wdata : a_wdata;
          be_d    = gnt[1] ? b_be    : a_be;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = cnt_inc;
        if (expired) begin
          state_d = IDLE;
          a_rv_d  = (owner == REQ_A);
          b_rv_d  = (owner == REQ_B);
          err_d   = 1'b1;
        end else if (m_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        // m_done takes priority over a simultaneous expiry
        if (m_done || expired) begin
          state_d = IDLE;
          a_rv_d  = (owner == REQ_A);
          b_rv_d  = (owner == REQ_B);
          err_d   = !m_done;
          rdata_d = (m_done && !write_q) ? m_rdata : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      cnt_q   <= '0;
      a_rv_q  <= 1'b0;
      b_rv_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      cnt_q   <= cnt_d;
      a_rv_q  <= a_rv_d;
      b_rv_q  <= b_rv_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign a_ready  = (state_q == IDLE) && gnt[0];
  assign b_ready  = (state_q == IDLE) && gnt[1];
  assign m_valid  = (state_q == ISSUE);
  assign busy     = (state_q != IDLE);
  assign m_write  = write_q;
  assign m_addr   = addr_q;
  assign m_wdata  = wdata_q;
  assign m_be     = be_q;
  assign a_rvalid = a_rv_q;
  assign b_rvalid = b_rv_q;
  assign a_err    = a_rv_q & err_q;
  assign b_err    = b_rv_q & err_q;
  assign a_rdata  = a_rv_q ? rdata_q : '0;
  assign b_rdata  = b_rv_q ? rdata_q : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

  typedef struct {
    logic        port;
    logic [15:0] rdata;
    logic        err;
    int          lat;
  } resp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [15:0] wd;
    logic [1:0]  be;
  } mreq_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready, a_write, a_rvalid, a_err;
  logic [31:0] a_addr;
  logic [15:0] a_wdata, a_rdata;
  logic [1:0]  a_be;
  logic        b_valid, b_ready, b_write, b_rvalid, b_err;
  logic [31:0] b_addr;
  logic [15:0] b_wdata, b_rdata;
  logic [1:0]  b_be;
  logic        m_valid, m_ready, m_write, m_done, busy;
  logic [31:0] m_addr;
  logic [15:0] m_wdata, m_rdata;
  logic [1:0]  m_be;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc [2];
  int nrv [2];
  logic mv_prev = 1'b0;

  resp_t rq[$];
  mreq_t mq[$];
  logic  gq[$];

  // frontend model configuration
  int          fe_rdy_dly = 0;
  int          fe_done_dly = 0;
  bit          fe_done_en = 1'b1;
  logic [15:0] fe_rdata = '0;

  sram_arbiter #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (16),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_write  (a_write),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_be     (a_be),
    .a_rvalid (a_rvalid),
    .a_rdata  (a_rdata),
    .a_err    (a_err),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_write  (b_write),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_be     (b_be),
    .b_rvalid (b_rvalid),
    .b_rdata  (b_rdata),
    .b_err    (b_err),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_write  (m_write),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_be     (m_be),
    .m_done   (m_done),
    .m_rdata  (m_rdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // Frontend model: ready after fe_rdy_dly cycles, done fe_done_dly cycles later
  initial begin
    m_ready = 1'b0;
    m_done  = 1'b0;
    m_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (m_valid && !rst) begin
        for (int i = 0; i < fe_rdy_dly; i++) begin @(posedge clk); #1; end
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        if (fe_done_en) begin
          for (int i = 0; i < fe_done_dly; i++) begin @(posedge clk); #1; end
          m_done  = 1'b1;
          m_rdata = fe_rdata;
          @(posedge clk); #1;
          m_done  = 1'b0;
          m_rdata = '0;
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic  g;
    mreq_t m;
    resp_t r;
    forever begin
      @(negedge clk);
      if (rst) begin
        mv_prev = 1'b0;
      end else begin
        if (a_ready || b_ready) begin
          if (gq.size() == 0) flag("unexpected_grant");
          else begin
            g = gq.pop_front();
            check("grant", 32'({b_ready, a_ready}), g ? 32'd2 : 32'd1);
            acc_cyc[g] = cyc + 1;
          end
        end
        if (m_valid && !mv_prev) begin
          if (mq.size() == 0) flag("unexpected_m_valid");
          else begin
            m = mq.pop_front();
            check("m_write", 32'(m_write), 32'(m.wr));
            check("m_addr", m_addr, m.addr);
            check("m_wdata", 32'(m_wdata), 32'(m.wd));
            check("m_be", 32'(m_be), 32'(m.be));
          end
        end
        mv_prev = m_valid;
        if (a_rvalid || b_rvalid) begin
          if (rq.size() == 0) flag("unexpected_rvalid");
          else begin
            r = rq.pop_front();
            check("rvalid_port", 32'({b_rvalid, a_rvalid}), r.port ? 32'd2 : 32'd1);
            if (r.port) begin
              check("b_rdata", 32'(b_rdata), 32'(r.rdata));
              check("b_err", 32'(b_err), 32'(r.err));
              check("a_idle_outs", 32'({a_rdata, a_err}), 32'd0);
            end else begin
              check("a_rdata", 32'(a_rdata), 32'(r.rdata));
              check("a_err", 32'(a_err), 32'(r.err));
              check("b_idle_outs", 32'({b_rdata, b_err}), 32'd0);
            end
            check("latency", 32'(cyc - acc_cyc[r.port]), 32'(r.lat));
            nrv[r.port]++;
          end
        end else begin
          check("quiet_outs", 32'({a_rdata, b_rdata, a_err, b_err}), 32'd0);
        end
      end
    end
  end

  task automatic push(input logic port, input logic wr, input logic [31:0] addr,
                      input logic [15:0] wd, input logic [1:0] be,
                      input logic [15:0] rd, input logic err, input int lat, input bit resp);
    mreq_t m;
    resp_t r;
    m.wr = wr; m.addr = addr; m.wd = wd; m.be = be;
    gq.push_back(port);
    mq.push_back(m);
    if (resp) begin
      r.port = port; r.rdata = rd; r.err = err; r.lat = lat;
      rq.push_back(r);
    end
  endtask

  task automatic set_fields(input logic port, input logic wr, input logic [31:0] addr,
                            input logic [15:0] wd, input logic [1:0] be);
    if (port) begin b_write = wr; b_addr = addr; b_wdata = wd; b_be = be; end
    else      begin a_write = wr; a_addr = addr; a_wdata = wd; a_be = be; end
  endtask

  task automatic issue(input logic port, input logic wr, input logic [31:0] addr,
                       input logic [15:0] wd, input logic [1:0] be);
    int t;
    @(posedge clk); #1;
    set_fields(port, wr, addr, wd, be);
    if (port) b_valid = 1'b1; else a_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(port ? b_ready : a_ready) && t < 50);
    if (t >= 50) flag("ready_timeout");
    @(posedge clk); #1;
    if (port) b_valid = 1'b0; else a_valid = 1'b0;
  endtask

  // Both ports request continuously; each drops valid after n accepts
  task automatic run_pair(input int n);
    int na, nb, t;
    na = 0; nb = 0; t = 0;
    @(posedge clk); #1;
    a_valid = 1'b1;
    b_valid = 1'b1;
    while ((na < n || nb < n) && t < 200) begin
      @(negedge clk);
      if (a_ready) na++;
      if (b_ready) nb++;
      @(posedge clk); #1;
      if (na >= n) a_valid = 1'b0;
      if (nb >= n) b_valid = 1'b0;
      t++;
    end
    if (t >= 200) flag("pair_timeout");
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic wait_resp(input int budget);
    int t;
    t = 0;
    while (rq.size() != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (rq.size() != 0) flag("resp_timeout");
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
    b_valid = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
    nrv[0] = 0; nrv[1] = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    repeat (2) @(negedge clk);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rvalid", 32'({a_rvalid, b_rvalid, a_err, b_err}), 32'd0);
    check("rst_fields", 32'({m_write, m_be, m_wdata}), 32'd0);
    check("rst_m_addr", m_addr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // contention from reset: A,B,A,B, immediate completion
    fe_rdy_dly = 0; fe_done_dly = 0; fe_done_en = 1'b1; fe_rdata = 16'h0A0A;
    set_fields(1'b0, 1'b0, 32'h0000_0100, 16'h0000, 2'b11);
    set_fields(1'b1, 1'b1, 32'h0000_0200, 16'h1111, 2'b01);
    for (int i = 0; i < 2; i++) begin
      push(1'b0, 1'b0, 32'h0000_0100, 16'h0000, 2'b11, 16'h0A0A, 1'b0, 2, 1'b1);
      push(1'b1, 1'b1, 32'h0000_0200, 16'h1111, 2'b01, 16'h0000, 1'b0, 2, 1'b1);
    end
    run_pair(2);
    wait_resp(60);
    check("a_rvalid_count", 32'(nrv[0]), 32'd2);
    check("b_rvalid_count", 32'(nrv[1]), 32'd2);

    // single read on A
    fe_rdy_dly = 1; fe_done_dly = 3; fe_rdata = 16'hBEEF;
    push(1'b0, 1'b0, 32'h0000_1234, 16'h0000, 2'b11, 16'hBEEF, 1'b0, 6, 1'b1);
    issue(1'b0, 1'b0, 32'h0000_1234, 16'h0000, 2'b11);
    wait_resp(40);

    // write on B, upper byte only; frontend rdata must not leak
    fe_rdy_dly = 0; fe_done_dly = 0; fe_rdata = 16'h7777;
    push(1'b1, 1'b1, 32'h0000_0010, 16'hA55A, 2'b10, 16'h0000, 1'b0, 2, 1'b1);
    issue(1'b1, 1'b1, 32'h0000_0010, 16'hA55A, 2'b10);
    wait_resp(40);

    // byte enable 00 forwarded unchanged
    push(1'b0, 1'b1, 32'h0000_0020, 16'h1234, 2'b00, 16'h0000, 1'b0, 2, 1'b1);
    issue(1'b0, 1'b1, 32'h0000_0020, 16'h1234, 2'b00);
    wait_resp(40);

    // timeout: done arrives two cycles after the forced error completion
    fe_rdy_dly = 1; fe_done_dly = 8; fe_rdata = 16'hDEAD;
    push(1'b0, 1'b0, 32'h0000_2000, 16'h0000, 2'b11, 16'h0000, 1'b1, 8, 1'b1);
    issue(1'b0, 1'b0, 32'h0000_2000, 16'h0000, 2'b11);
    wait_resp(40);
    repeat (6) @(negedge clk);
    check("timeout_busy", 32'(busy), 32'd0);

    // done on the final timeout cycle wins
    fe_rdy_dly = 1; fe_done_dly = 5; fe_rdata = 16'h0042;
    push(1'b1, 1'b0, 32'h0000_3000, 16'h0000, 2'b01, 16'h0042, 1'b0, 8, 1'b1);
    issue(1'b1, 1'b0, 32'h0000_3000, 16'h0000, 2'b01);
    wait_resp(40);

    // async reset while in WAIT
    fe_rdy_dly = 0; fe_done_en = 1'b0;
    push(1'b1, 1'b0, 32'h0000_4000, 16'h0000, 2'b11, 16'h0000, 1'b0, 0, 1'b0);
    issue(1'b1, 1'b0, 32'h0000_4000, 16'h0000, 2'b11);
    @(posedge clk); #2;
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("async_m_valid", 32'(m_valid), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    fe_done_en = 1'b1; fe_done_dly = 0; fe_rdata = 16'h5A5A;
    set_fields(1'b0, 1'b0, 32'h0000_5000, 16'h0000, 2'b11);
    set_fields(1'b1, 1'b0, 32'h0000_6000, 16'h0000, 2'b11);
    push(1'b0, 1'b0, 32'h0000_5000, 16'h0000, 2'b11, 16'h5A5A, 1'b0, 2, 1'b1);
    push(1'b1, 1'b0, 32'h0000_6000, 16'h0000, 2'b11, 16'h5A5A, 1'b0, 2, 1'b1);
    run_pair(1);
    wait_resp(60);

    repeat (4) @(negedge clk);
    check("left_grants", 32'(gq.size()), 32'd0);
    check("left_mreqs", 32'(mq.size()), 32'd0);
    check("left_resps", 32'(rq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external SRAM frontend (multiplexed 16-bit AD bus, ALE0/ALE1 address phases, OE/WE/BHE strobes) between two requesters.
- Port A is the programmer loader and port B is the core data path.
- Performs round-robin arbitration, holds one outstanding transaction at a time, and routes completion and read data back to the winner.
- A timeout guards against a hung frontend.

Parameters:
- ADDR_WIDTH, 32, byte address width presented to the frontend
- DATA_WIDTH, 16, data width (matches the IO bus)
- TIMEOUT_CYCLES, 64, cycles from accept to forced error completion; 0 disables the timeout

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- a_valid, b_valid  in  1  request pending; must hold valid and fields stable until ready
- a_ready, b_ready  out  1  one-cycle accept pulse
- a_write, b_write  in  1  1=write, 0=read
- a_addr, b_addr  in  ADDR_WIDTH  request address
- a_wdata, b_wdata  in  DATA_WIDTH  write data
- a_be, b_be  in  2  byte enables; [1] drives bhe
- a_rvalid, b_rvalid  out  1  one-cycle completion pulse (reads and writes)
- a_rdata, b_rdata  out  DATA_WIDTH  read data, valid with rvalid
- a_err, b_err  out  1  completion was a timeout, valid with rvalid
- m_valid  out  1  request to frontend
- m_ready  in  1  frontend accepted request
- m_write, m_addr, m_wdata, m_be  out  -  latched request fields
- m_done  in  1  frontend transaction finished
- m_rdata  in  DATA_WIDTH  frontend read data, valid with m_done
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high (rst).
- State on reset:
  - All outputs are 0 and the state is IDLE.
  - last_grant=B, so A wins the first tie.
  - The timeout counter is 0 and the latched fields are 0.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If exactly one valid is high, grant it.
  - If both are high, grant the port that is not last_grant.
  - The winner's ready is combinational: (state==IDLE) & grant.
  - On the accept edge: latch write, addr, wdata, be and owner; clear the counter; go to ISSUE.
  - The loser's ready stays 0 and its request waits.
- ISSUE:
  - m_valid=1 with the latched fields.
  - On m_ready go to WAIT, with m_valid deasserting the next cycle.
  - m_done in ISSUE is ignored.
- WAIT:
  - m_valid=0.
  - On m_done: owner_rvalid is pulsed for one cycle, rdata is registered from m_rdata (reads; 0 for writes), err=0.
  - last_grant becomes the owner; go to IDLE.
- Timeout:
  - The counter increments every cycle in ISSUE and WAIT.
  - When it equals TIMEOUT_CYCLES-1 and m_done is absent: pulse owner_rvalid with err=1 and rdata=0, deassert m_valid, update last_grant, go to IDLE.
  - m_done and expiry in the same cycle: m_done wins, err=0.
  - m_done arriving in IDLE, from a stale transaction, is ignored.
- Non-owner outputs: rvalid, err and rdata stay 0 for the port that is not the owner. rdata holds its value only during the rvalid cycle, then returns to 0.
- Latency: rvalid is registered, one cycle after m_done is sampled. The earliest next accept is the cycle rvalid is high, since the state is already IDLE.
- Fairness: alternating grants under continuous contention. No starvation: the maximum wait is one transaction.
- Async reset mid-transaction:
  - Returns to IDLE immediately and m_valid drops the same instant.
  - No rvalid is generated for the aborted request.
  - The frontend is reset from the same rst.
- Width rules:
  - The counter is $clog2(TIMEOUT_CYCLES+1) bits and saturates.
  - be=2'b00 is forwarded unchanged; no special case.

Decomposition:
- Package sram_pkg holds:
  - state encoding: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2
  - requester ids: REQ_A=1'b0, REQ_B=1'b1
  - byte-enable constants: BE_LO=2'b01, BE_HI=2'b10, BE_WORD=2'b11
- One sub-module, rr_arbiter2. Inputs: clk, rst, req[1:0], advance. Outputs: gnt[1:0] one-hot, and the last_grant register updated on advance.
- The FSM, latches, timeout and response routing stay in sram_arbiter.

Test Plan:
- Single read:
  - Stimulus: A read addr=0x0000_1234. Frontend raises m_ready 1 cycle after m_valid and m_done 3 cycles later with m_rdata=0xBEEF.
  - Required: a_ready for 1 cycle; m_addr=0x1234, m_write=0; a_rvalid=1, a_rdata=0xBEEF, a_err=0 one cycle after m_done; b_* stays 0.
- Contention from reset:
  - Stimulus: a_valid and b_valid both held, 4 transactions, each completing immediately.
  - Required: grant order A,B,A,B; each port sees exactly 2 rvalid pulses.
- Write with upper byte:
  - Stimulus: B write addr=0x10, wdata=0xA55A, be=2'b10.
  - Required: m_be=2'b10, m_wdata=0xA55A, m_write=1; b_rvalid=1, b_rdata=0x0000.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8; A read; m_ready given, m_done never given.
  - Required: a_rvalid=1 and a_err=1 exactly 8 cycles after accept; busy returns to 0.
  - Follow-up: m_done injected 2 cycles later is ignored.
- Collision on the final cycle:
  - Stimulus: m_done asserted on the final timeout cycle with m_rdata=0x0042.
  - Required: err=0, rdata=0x0042.
- Reset mid-transaction:
  - Stimulus: rst pulsed in WAIT.
  - Required: m_valid, busy and all rvalid go 0 asynchronously; the first post-reset tie is granted to A.
